// File: rtl/bin_logic_pkg.sv
// bin_logic_pkg: shared state encoding, truth-table column constants and table-width helper
package bin_logic_pkg;
  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;
  localparam logic [15:0] COL_A = 16'h00FF;
  localparam logic [15:0] COL_B = 16'h0F0F;
  localparam logic [15:0] COL_C = 16'h3333;
  localparam logic [15:0] COL_D = 16'h5555;
  function automatic int tw_of(input int n_in);
    return 1 << n_in;
  endfunction
endpackage

// File: rtl/bin_logic_sweep_ctrl_if.sv
// bin_logic_sweep_ctrl_if: host handshake and function-unit signals; BIN_LOGIC_EXPECT_CHECK_EN adds expect/mismatch
interface bin_logic_sweep_ctrl_if #(parameter int TW = 16);
  logic start;
  logic busy;
  logic done;
  logic table_valid;
  logic [TW-1:0] table_out;
  logic fa;
  logic fb;
  logic fc;
  logic fd;
  logic fx;
`ifdef BIN_LOGIC_EXPECT_CHECK_EN
  logic [TW-1:0] expect_tt;
  logic [TW-1:0] mismatch_mask;
  logic mismatch;
`endif
  modport master (
`ifdef BIN_LOGIC_EXPECT_CHECK_EN
    output expect_tt, input mismatch, mismatch_mask,
`endif
    output start, fx, input busy, done, table_valid, table_out, fa, fb, fc, fd
  );
  modport slave (
`ifdef BIN_LOGIC_EXPECT_CHECK_EN
    input expect_tt, output mismatch, mismatch_mask,
`endif
    input start, fx, output busy, done, table_valid, table_out, fa, fb, fc, fd
  );
endinterface

// File: rtl/bin_logic_capture_pipe.sv
// bin_logic_capture_pipe: LAT-deep delay of {valid, column} matching the function unit latency
module bin_logic_capture_pipe #(
  parameter int N_IN = 4,
  parameter int LAT = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic [N_IN-1:0] in_col,
  output logic out_valid,
  output logic [N_IN-1:0] out_col
);
  if (LAT == 0) begin : g_wire
    logic unused_clk;
    assign unused_clk = clk ^ rst;
    assign out_valid = in_valid;
    assign out_col = in_col;
  end else begin : g_pipe
    logic [N_IN:0] stg [LAT];
    // shift the column tag alongside the unit's internal pipeline
    always_ff @(posedge clk or posedge rst)
      if (rst) for (int i = 0; i < LAT; i++) stg[i] <= '0;
      else begin
        stg[0] <= {in_valid, in_col};
        for (int i = 1; i < LAT; i++) stg[i] <= stg[i-1];
      end
    assign {out_valid, out_col} = stg[LAT-1];
  end
endmodule

// File: rtl/bin_logic_sweep_ctrl.sv
// bin_logic_sweep_ctrl: sweeps all input columns through a function unit and builds its truth table; option BIN_LOGIC_EXPECT_CHECK_EN
module bin_logic_sweep_ctrl
  import bin_logic_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int LAT = 0
) (
  input logic clk,
  input logic rst,
  bin_logic_sweep_ctrl_if.slave bus
);
  localparam int TW = tw_of(N_IN);
  state_t state;
  logic [N_IN-1:0] idx;
  logic [2:0] drain_cnt;
  logic p_valid;
  logic [N_IN-1:0] p_col;
`ifdef BIN_LOGIC_EXPECT_CHECK_EN
  logic [TW-1:0] exp_q;
`endif
  assign bus.fa = ~idx[3];
  assign bus.fb = ~idx[2];
  assign bus.fc = ~idx[1];
  assign bus.fd = ~idx[0];
  bin_logic_capture_pipe #(.N_IN(N_IN), .LAT(LAT)) u_pipe (
    .clk(clk), .rst(rst), .in_valid(state == SWEEP), .in_col(idx),
    .out_valid(p_valid), .out_col(p_col)
  );
  // sequencer: start/sweep/drain/done with registered handshake and table capture
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      drain_cnt <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.table_valid <= 1'b0;
      bus.table_out <= '0;
`ifdef BIN_LOGIC_EXPECT_CHECK_EN
      exp_q <= '0;
      bus.mismatch <= 1'b0;
      bus.mismatch_mask <= '0;
`endif
    end else begin
      bus.done <= 1'b0;
      if (p_valid) bus.table_out[p_col] <= bus.fx;
      case (state)
        IDLE: if (bus.start) begin
          state <= SWEEP;
          idx <= '0;
          bus.table_out <= '0;
          bus.table_valid <= 1'b0;
          bus.busy <= 1'b1;
`ifdef BIN_LOGIC_EXPECT_CHECK_EN
          exp_q <= bus.expect_tt;
          bus.mismatch <= 1'b0;
          bus.mismatch_mask <= '0;
`endif
        end
        SWEEP: begin
          idx <= idx + 1'b1;
          drain_cnt <= '0;
          if (&idx) state <= (LAT > 0) ? DRAIN : DONE;
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + 1'b1;
          if (drain_cnt == 3'(LAT - 1)) state <= DONE;
        end
        DONE: begin
          state <= IDLE;
          bus.done <= 1'b1;
          bus.table_valid <= 1'b1;
          bus.busy <= 1'b0;
`ifdef BIN_LOGIC_EXPECT_CHECK_EN
          bus.mismatch_mask <= bus.table_out ^ exp_q;
          bus.mismatch <= |(bus.table_out ^ exp_q);
`endif
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_bin_logic_sweep_ctrl.sv
// tb_bin_logic_sweep_ctrl: directed vector bench for combinational and 2-stage registered function units
module tb_bin_logic_sweep_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] fsel = 3'd0;
  logic r1, r2;
  int n_cmp = 0;
  int n_bad = 0;
  bin_logic_sweep_ctrl_if #(.TW(16)) i0 ();
  bin_logic_sweep_ctrl_if #(.TW(16)) i2 ();
  bin_logic_sweep_ctrl #(.N_IN(4), .LAT(0)) dut0 (.clk(clk), .rst(rst), .bus(i0));
  bin_logic_sweep_ctrl #(.N_IN(4), .LAT(2)) dut2 (.clk(clk), .rst(rst), .bus(i2));
  always #5 clk = ~clk;
  always_comb
    case (fsel)
      3'd0: i0.fx = i0.fa;
      3'd1: i0.fx = i0.fa & i0.fb;
      3'd2: i0.fx = i0.fd;
      3'd3: i0.fx = i0.fa ^ i0.fb ^ i0.fc ^ i0.fd;
      3'd4: i0.fx = i0.fa | i0.fd;
      default: i0.fx = i0.fc;
    endcase
  always @(posedge clk) begin
    r1 <= i2.fc;
    r2 <= r1;
  end
  assign i2.fx = r2;
  typedef struct {
    int lat;
    logic [2:0] fsel;
    logic [15:0] exp_tt;
    int exp_cyc;
    logic [15:0] expect_v;
  } vec_t;
  vec_t vecs[7];
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask
  task automatic run(input vec_t v);
    int cyc;
    bit got;
    fsel = v.fsel;
`ifdef BIN_LOGIC_EXPECT_CHECK_EN
    i0.expect_tt = v.expect_v;
`endif
    @(negedge clk);
    if (v.lat == 0) i0.start = 1'b1; else i2.start = 1'b1;
    @(negedge clk);
    i0.start = 1'b0;
    i2.start = 1'b0;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) chk("busy_in_sweep", (v.lat == 0) ? i0.busy : i2.busy, 1);
      if ((v.lat == 0) ? i0.done : i2.done) got = 1'b1;
    end
    chk("done_cycle", cyc, v.exp_cyc);
    chk("table_out", (v.lat == 0) ? i0.table_out : i2.table_out, v.exp_tt);
    chk("table_valid", (v.lat == 0) ? i0.table_valid : i2.table_valid, 1);
    chk("busy_at_done", (v.lat == 0) ? i0.busy : i2.busy, 0);
`ifdef BIN_LOGIC_EXPECT_CHECK_EN
    if (v.lat == 0) begin
      chk("mismatch_mask", i0.mismatch_mask, v.exp_tt ^ v.expect_v);
      chk("mismatch", i0.mismatch, (v.exp_tt != v.expect_v) ? 1 : 0);
    end
`endif
    @(negedge clk);
    chk("done_pulse_end", (v.lat == 0) ? i0.done : i2.done, 0);
    chk("table_hold", (v.lat == 0) ? i0.table_out : i2.table_out, v.exp_tt);
  endtask
  initial begin
    int nd, de, cyc;
    vecs[0] = '{0, 3'd0, 16'h00FF, 17, 16'h00FF};
    vecs[1] = '{0, 3'd1, 16'h000F, 17, 16'h000F};
    vecs[2] = '{0, 3'd2, 16'h5555, 17, 16'h5555};
    vecs[3] = '{0, 3'd3, 16'h6996, 17, 16'h6996};
    vecs[4] = '{0, 3'd4, 16'h55FF, 17, 16'h55FF};
    vecs[5] = '{0, 3'd4, 16'h55FF, 17, 16'h55FE};
    vecs[6] = '{2, 3'd0, 16'h3333, 19, 16'h0000};
    i0.start = 1'b0;
    i2.start = 1'b0;
`ifdef BIN_LOGIC_EXPECT_CHECK_EN
    i0.expect_tt = '0;
    i2.expect_tt = '0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_busy", i0.busy, 0);
    chk("rst_done", i0.done, 0);
    chk("rst_valid", i0.table_valid, 0);
    chk("rst_table", i0.table_out, 0);
    chk("rst_fabcd", {i0.fa, i0.fb, i0.fc, i0.fd}, 4'hF);
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 7; k++) run(vecs[k]);
    fsel = 3'd1;
    i0.start = 1'b1;
    @(negedge clk);
    nd = 0;
    de = 0;
    for (int e = 1; e <= 18; e++) begin
      @(negedge clk);
      if (i0.done) begin
        nd++;
        de = e;
      end
    end
    chk("held_done_count", nd, 1);
    chk("held_done_cycle", de, 17);
    chk("held_restart_busy", i0.busy, 1);
    chk("held_restart_valid", i0.table_valid, 0);
    i0.start = 1'b0;
    cyc = 0;
    while (!i0.done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("held_second_done", i0.done, 1);
    chk("held_second_table", i0.table_out, 16'h000F);
    fsel = 3'd0;
    @(negedge clk);
    i0.start = 1'b1;
    @(negedge clk);
    i0.start = 1'b0;
    repeat (8) @(negedge clk);
    chk("partial_table", i0.table_out, 16'h00FF);
    rst = 1'b1;
    #1;
    chk("midrst_busy", i0.busy, 0);
    chk("midrst_valid", i0.table_valid, 0);
    chk("midrst_table", i0.table_out, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    nd = 0;
    for (int e = 0; e < 25; e++) begin
      @(negedge clk);
      if (i0.done) nd++;
    end
    chk("midrst_no_done", nd, 0);
    run(vecs[0]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
